// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS control path: FSM states, opcodes, funct codes, ALU ops.
package mips_pkg;

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_EXEC_R = 4'd2;
    localparam logic [3:0] S_WB_R   = 4'd3;
    localparam logic [3:0] S_ADDR   = 4'd4;
    localparam logic [3:0] S_MEM_RD = 4'd5;
    localparam logic [3:0] S_MEM_WR = 4'd6;
    localparam logic [3:0] S_WB_LW  = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_TRAP   = 4'd9;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mips_alu_decode.sv
// R-type funct to ALU operation decode; also used by the single-cycle control path.
module mips_alu_decode
    import mips_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_op,
    output logic       legal
);

    always_comb begin
        alu_op = ALU_ADD;
        legal  = 1'b1;
        case (funct)
            FN_ADD:  alu_op = ALU_ADD;
            FN_SUB:  alu_op = ALU_SUB;
            FN_AND:  alu_op = ALU_AND;
            FN_OR:   alu_op = ALU_OR;
            FN_SLT:  alu_op = ALU_SLT;
            default: legal  = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS sequencer: fetch/decode/execute/memory/writeback with ready handshakes,
// retired-instruction counter and sticky illegal/bus-error traps.
module mips_multicycle_control
    import mips_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int MAX_WAIT = 15
)
(
    input  logic             clock,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             ir_write,
    output logic             sig_reg_dst,
    output logic             sig_reg_write,
    output logic             sig_alu_src,
    output logic             sig_mem_read,
    output logic             sig_mem_write,
    output logic             sig_mem_to_reg,
    output logic             sig_pc_src,
    output logic [2:0]       alu_op,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired,
    output logic             illegal,
    output logic             bus_error
);

    localparam int WAIT_W = 16;

    logic [3:0]        state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic [2:0]        funct_op;
    logic              funct_legal;
    logic              waiting;
    logic              timeout;
    logic              retire;
    logic              illegal_set;

    mips_alu_decode u_alu_decode (
        .funct  (funct),
        .alu_op (funct_op),
        .legal  (funct_legal)
    );

    always_comb begin
        waiting = 1'b0;
        case (state)
            S_FETCH:            waiting = !imem_ready;
            S_MEM_RD, S_MEM_WR: waiting = !dmem_ready;
            default:            waiting = 1'b0;
        endcase
    end

    // Trip on the edge where this wait cycle would bring the count to MAX_WAIT.
    assign timeout = (MAX_WAIT > 0) && waiting && (wait_cnt == WAIT_W'(MAX_WAIT - 1));

    always_comb begin
        state_next  = state;
        retire      = 1'b0;
        illegal_set = 1'b0;
        case (state)
            S_FETCH: if (imem_ready) state_next = S_DECODE;
            S_DECODE: begin
                if (opcode == OP_RTYPE && funct_legal) state_next = S_EXEC_R;
                else if (opcode == OP_LW || opcode == OP_SW) state_next = S_ADDR;
                else if (opcode == OP_BEQ) state_next = S_BRANCH;
                else begin
                    state_next  = S_TRAP;
                    illegal_set = 1'b1;
                end
            end
            S_EXEC_R: state_next = S_WB_R;
            S_WB_R: begin
                state_next = S_FETCH;
                retire     = 1'b1;
            end
            S_ADDR:   state_next = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: if (dmem_ready) state_next = S_WB_LW;
            S_WB_LW: begin
                state_next = S_FETCH;
                retire     = 1'b1;
            end
            S_MEM_WR: begin
                if (dmem_ready) begin
                    state_next = S_FETCH;
                    retire     = 1'b1;
                end
            end
            S_BRANCH: begin
                state_next = S_FETCH;
                retire     = 1'b1;
            end
            S_TRAP:   state_next = S_TRAP;
            default:  state_next = S_TRAP;
        endcase
        if (timeout) state_next = S_TRAP;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_FETCH;
            retired   <= '0;
            illegal   <= 1'b0;
            bus_error <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            state <= state_next;
            if (retire)      retired   <= retired + CNT_W'(1);
            if (illegal_set) illegal   <= 1'b1;
            if (timeout)     bus_error <= 1'b1;
            if (state_next != state) wait_cnt <= '0;
            else if (waiting)        wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    always_comb begin
        pc_write       = 1'b0;
        ir_write       = 1'b0;
        sig_reg_dst    = 1'b0;
        sig_reg_write  = 1'b0;
        sig_alu_src    = 1'b0;
        sig_mem_read   = 1'b0;
        sig_mem_write  = 1'b0;
        sig_mem_to_reg = 1'b0;
        sig_pc_src     = 1'b0;
        alu_op         = ALU_ADD;
        case (state)
            S_FETCH: begin
                ir_write = imem_ready;
                pc_write = imem_ready;
            end
            S_EXEC_R: alu_op = funct_op;
            S_WB_R: begin
                sig_reg_write = 1'b1;
                sig_reg_dst   = 1'b1;
                alu_op        = funct_op;
            end
            S_ADDR: sig_alu_src = 1'b1;
            S_MEM_RD: begin
                sig_alu_src  = 1'b1;
                sig_mem_read = 1'b1;
            end
            S_MEM_WR: begin
                sig_alu_src   = 1'b1;
                sig_mem_write = 1'b1;
            end
            S_WB_LW: begin
                sig_reg_write  = 1'b1;
                sig_mem_to_reg = 1'b1;
            end
            S_BRANCH: begin
                alu_op     = ALU_SUB;
                pc_write   = zero;
                sig_pc_src = zero;
            end
            default: ;
        endcase
        // Reset aborts the current instruction before any write can land.
        if (reset) begin
            pc_write      = 1'b0;
            ir_write      = 1'b0;
            sig_reg_write = 1'b0;
            sig_mem_read  = 1'b0;
            sig_mem_write = 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench: builds the expected per-cycle trace of a randomized instruction stream from
// the sequencing rules, then replays it against the DUT and compares every cycle.
module tb_mips_multicycle_control;

    localparam int CNT_W    = 4;
    localparam int MAX_WAIT = 15;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [5:0]       opcode = '0;
    logic [5:0]       funct = '0;
    logic             zero = 1'b0;
    logic             imem_ready = 1'b0;
    logic             dmem_ready = 1'b0;
    logic             pc_write, ir_write, sig_reg_dst, sig_reg_write, sig_alu_src;
    logic             sig_mem_read, sig_mem_write, sig_mem_to_reg, sig_pc_src;
    logic [2:0]       alu_op;
    logic [3:0]       state;
    logic [CNT_W-1:0] retired;
    logic             illegal, bus_error;

    mips_multicycle_control #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clock(clock), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .pc_write(pc_write),
        .ir_write(ir_write), .sig_reg_dst(sig_reg_dst), .sig_reg_write(sig_reg_write),
        .sig_alu_src(sig_alu_src), .sig_mem_read(sig_mem_read), .sig_mem_write(sig_mem_write),
        .sig_mem_to_reg(sig_mem_to_reg), .sig_pc_src(sig_pc_src), .alu_op(alu_op),
        .state(state), .retired(retired), .illegal(illegal), .bus_error(bus_error)
    );

    always #5 clock = ~clock;

    // care: [0] reg_dst, [1] alu_src, [2] mem_to_reg, [3] pc_src, [4] alu_op
    typedef struct packed {
        logic             rst, imem, dmem, z;
        logic [5:0]       op, fn;
        logic [3:0]       st;
        logic             pcw, irw, regw, memr, memw;
        logic             rdst, asrc, m2r, psrc;
        logic [2:0]       aop;
        logic [4:0]       care;
        logic [CNT_W-1:0] ret;
        logic             ill, berr;
    } cyc_t;

    cyc_t             q[$];
    cyc_t             cur;
    logic [CNT_W-1:0] m_ret = '0;
    logic             m_ill = 1'b0;
    logic             m_berr = 1'b0;
    bit               chk_en = 1'b0;
    bit               plan_ready = 1'b0;
    int               n_cmp = 0;
    int               n_bad = 0;
    int               pin_act[12];
    int               pin_exp[12];

    function automatic logic [2:0] r_alu(input logic [5:0] fn);
        case (fn)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic bit r_legal(input logic [5:0] fn);
        return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    endfunction

    function automatic logic [5:0] pick_fn(input int i);
        case (i)
            0:       return 6'b100000;
            1:       return 6'b100010;
            2:       return 6'b100100;
            3:       return 6'b100101;
            default: return 6'b101010;
        endcase
    endfunction

    function automatic cyc_t base(input logic [3:0] st, input logic [5:0] op, input logic [5:0] fn);
        cyc_t c;
        c      = '0;
        c.st   = st;
        c.op   = op;
        c.fn   = fn;
        c.aop  = 3'b010;
        c.care = 5'b10000;
        c.imem = 1'($urandom);
        c.dmem = 1'($urandom);
        c.z    = 1'($urandom);
        c.ret  = m_ret;
        c.ill  = m_ill;
        c.berr = m_berr;
        return c;
    endfunction

    function automatic int cnt(input int s, input int which);
        int n = 0;
        for (int i = s; i < q.size(); i++) begin
            case (which)
                0:       n += int'(q[i].memr);
                1:       n += int'(q[i].memw);
                2:       n += int'(q[i].regw);
                default: n += int'(q[i].pcw);
            endcase
        end
        return n;
    endfunction

    task automatic plan_reset(input logic [3:0] st, input logic [5:0] op, input logic [5:0] fn);
        cyc_t c;
        c      = base(st, op, fn);
        c.rst  = 1'b1;
        c.care = '0;
        q.push_back(c);
        m_ret  = '0;
        m_ill  = 1'b0;
        m_berr = 1'b0;
    endtask

    task automatic plan_trap(input logic [5:0] op, input logic [5:0] fn);
        for (int i = 0; i < 4; i++) q.push_back(base(4'd9, op, fn));
        plan_reset(4'd9, op, fn);
    endtask

    task automatic plan_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                              input int iw, input int dw);
        cyc_t c;
        bit   lw;
        for (int i = 0; i < iw; i++) begin
            c = base(4'd0, op, fn); c.imem = 1'b0; c.care[3] = 1'b1;
            q.push_back(c);
            if (MAX_WAIT > 0 && i + 1 == MAX_WAIT) begin
                m_berr = 1'b1;
                plan_trap(op, fn);
                return;
            end
        end
        c = base(4'd0, op, fn); c.imem = 1'b1; c.irw = 1'b1; c.pcw = 1'b1; c.care[3] = 1'b1;
        q.push_back(c);
        q.push_back(base(4'd1, op, fn));
        if (op == 6'b000000 && r_legal(fn)) begin
            c = base(4'd2, op, fn); c.care[1] = 1'b1; c.aop = r_alu(fn);
            q.push_back(c);
            c = base(4'd3, op, fn); c.regw = 1'b1; c.rdst = 1'b1; c.care[2:0] = 3'b101;
            c.aop = r_alu(fn);
            q.push_back(c);
            m_ret = m_ret + 1'b1;
        end else if (op == 6'b100011 || op == 6'b101011) begin
            lw = (op == 6'b100011);
            c = base(4'd4, op, fn); c.asrc = 1'b1; c.care[1] = 1'b1;
            q.push_back(c);
            for (int i = 0; i < dw; i++) begin
                c = base(lw ? 4'd5 : 4'd6, op, fn); c.dmem = 1'b0;
                c.asrc = 1'b1; c.care[1] = 1'b1; c.memr = lw; c.memw = !lw;
                q.push_back(c);
                if (MAX_WAIT > 0 && i + 1 == MAX_WAIT) begin
                    m_berr = 1'b1;
                    plan_trap(op, fn);
                    return;
                end
            end
            c = base(lw ? 4'd5 : 4'd6, op, fn); c.dmem = 1'b1;
            c.asrc = 1'b1; c.care[1] = 1'b1; c.memr = lw; c.memw = !lw;
            q.push_back(c);
            if (lw) begin
                c = base(4'd7, op, fn); c.regw = 1'b1; c.m2r = 1'b1; c.care[2:0] = 3'b101;
                q.push_back(c);
            end
            m_ret = m_ret + 1'b1;
        end else if (op == 6'b000100) begin
            c = base(4'd8, op, fn); c.z = z; c.aop = 3'b110;
            c.pcw = z; c.psrc = z; c.care[3] = 1'b1;
            q.push_back(c);
            m_ret = m_ret + 1'b1;
        end else begin
            m_ill = 1'b1;
            plan_trap(op, fn);
        end
    endtask

    // SW aborted by reset after one MEM_WR wait cycle, with dmem_ready arriving in the reset cycle.
    task automatic plan_reset_in_memwr();
        cyc_t c;
        c = base(4'd0, 6'b101011, 6'd0); c.imem = 1'b1; c.irw = 1'b1; c.pcw = 1'b1;
        c.care[3] = 1'b1;
        q.push_back(c);
        q.push_back(base(4'd1, 6'b101011, 6'd0));
        c = base(4'd4, 6'b101011, 6'd0); c.asrc = 1'b1; c.care[1] = 1'b1;
        q.push_back(c);
        c = base(4'd6, 6'b101011, 6'd0); c.dmem = 1'b0; c.asrc = 1'b1; c.care[1] = 1'b1;
        c.memw = 1'b1;
        q.push_back(c);
        c = base(4'd6, 6'b101011, 6'd0); c.dmem = 1'b1; c.rst = 1'b1; c.care = '0;
        q.push_back(c);
        m_ret = '0; m_ill = 1'b0; m_berr = 1'b0;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    initial begin
        int s;
        int sel, iw, dw;
        logic [5:0] op, fn;
        s = q.size(); plan_instr(6'b000000, 6'b100000, 1'b0, 0, 0);
        pin_act[0] = q.size() - s; pin_exp[0] = 4;
        pin_act[1] = cnt(s, 2);    pin_exp[1] = 1;
        s = q.size(); plan_instr(6'b100011, 6'd0, 1'b0, 0, 3);
        pin_act[2] = q.size() - s; pin_exp[2] = 8;
        pin_act[3] = cnt(s, 0);    pin_exp[3] = 4;
        s = q.size(); plan_instr(6'b000100, 6'd0, 1'b1, 0, 0);
        pin_act[4] = q.size() - s; pin_exp[4] = 3;
        pin_act[5] = cnt(s, 3);    pin_exp[5] = 2;
        s = q.size(); plan_instr(6'b000100, 6'd0, 1'b0, 0, 0);
        pin_act[6] = q.size() - s; pin_exp[6] = 3;
        pin_act[7] = cnt(s, 3);    pin_exp[7] = 1;
        plan_instr(6'b111111, 6'd0, 1'b0, 0, 0);
        s = q.size(); plan_instr(6'b101011, 6'd0, 1'b0, 1, 40);
        pin_act[8] = cnt(s, 1);    pin_exp[8] = 15;
        pin_act[9] = q.size() - s; pin_exp[9] = 1 + 3 + 15 + 5;
        s = q.size(); plan_instr(6'b101011, 6'd0, 1'b0, 0, 14);
        pin_act[10] = cnt(s, 1);   pin_exp[10] = 15;
        pin_act[11] = int'(m_ret); pin_exp[11] = 1;
        plan_reset_in_memwr();
        // 18 back-to-back R-types push the 4-bit retired counter through its wrap.
        for (int k = 0; k < 18; k++)
            plan_instr(6'b000000, pick_fn($urandom_range(0, 4)), 1'b0, $urandom_range(0, 2), 0);
        plan_instr(6'b000000, 6'b100000, 1'b0, 14, 0);
        plan_instr(6'b000000, 6'b100000, 1'b0, 20, 0);
        for (int k = 0; k < 70; k++) begin
            sel = $urandom_range(0, 15);
            iw  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 18) : $urandom_range(0, 2);
            dw  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 18) : $urandom_range(0, 2);
            fn  = pick_fn($urandom_range(0, 4));
            if (sel < 5)       op = 6'b000000;
            else if (sel < 8)  op = 6'b100011;
            else if (sel < 11) op = 6'b101011;
            else if (sel < 14) op = 6'b000100;
            else if (sel == 14) begin op = 6'b000000; fn = 6'($urandom_range(0, 63)); end
            else               op = 6'($urandom_range(0, 63));
            plan_instr(op, fn, 1'($urandom), iw, dw);
        end
        plan_ready = 1'b1;

        repeat (2) @(posedge clock);
        for (int i = 0; i < q.size(); i++) begin
            @(posedge clock);
            #1;
            cur        = q[i];
            reset      = cur.rst;
            opcode     = cur.op;
            funct      = cur.fn;
            zero       = cur.z;
            imem_ready = cur.imem;
            dmem_ready = cur.dmem;
            chk_en     = 1'b1;
        end
        @(posedge clock);
        #1 chk_en = 1'b0;
        @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : compare
        logic [18+CNT_W-1:0] act, exp, mask;
        int cyc;
        cyc = 0;
        wait (plan_ready);
        for (int i = 0; i < 12; i++) check($sformatf("plan%0d", i), pin_act[i], pin_exp[i]);
        forever begin
            @(negedge clock);
            if (chk_en) begin
                act  = {state, pc_write, ir_write, sig_reg_write, sig_mem_read, sig_mem_write,
                        sig_reg_dst, sig_alu_src, sig_mem_to_reg, sig_pc_src, alu_op,
                        retired, illegal, bus_error};
                exp  = {cur.st, cur.pcw, cur.irw, cur.regw, cur.memr, cur.memw,
                        cur.rdst, cur.asrc, cur.m2r, cur.psrc, cur.aop,
                        cur.ret, cur.ill, cur.berr};
                mask = {4'hF, 5'h1F, cur.care[0], cur.care[1], cur.care[2], cur.care[3],
                        {3{cur.care[4]}}, {CNT_W{1'b1}}, 2'b11};
                n_cmp++;
                if ((act & mask) !== (exp & mask)) begin
                    n_bad++;
                    $display("FAIL cycle%0d st=%0d: got %h, expected %h (mask %h)",
                             cyc, cur.st, act, exp, mask);
                end
                cyc++;
            end
        end
    end

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Multicycle sequencer for the single-datapath MIPS core: ALU, register file, instruction and data memories, PC adders.
- Replaces the single-cycle combinational control decode with a Moore/Mealy FSM.
- Steps each instruction through fetch, decode, execute, memory and writeback, and inserts wait states on memory-ready handshakes.
- Counts retired instructions and traps on illegal encodings or memory timeouts.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.
- MAX_WAIT, 15, maximum consecutive wait cycles on a memory handshake before bus-error trap; 0 disables the timeout.

Ports:
- clock  input  1  core clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- opcode  input  6  instruction[31:26] from the instruction register.
- funct  input  6  instruction[5:0] from the instruction register.
- zero  input  1  ALU zero flag.
- imem_ready  input  1  instruction memory has valid data this cycle.
- dmem_ready  input  1  data memory read data valid / write accepted this cycle.
- pc_write  output  1  load PC this cycle.
- ir_write  output  1  load instruction register this cycle.
- sig_reg_dst  output  1  1 selects rd, 0 selects rt.
- sig_reg_write  output  1  register file write strobe.
- sig_alu_src  output  1  1 selects sign-extended immediate.
- sig_mem_read  output  1  data memory read request.
- sig_mem_write  output  1  data memory write request.
- sig_mem_to_reg  output  1  1 selects memory data for writeback.
- sig_pc_src  output  1  1 selects branch target, 0 selects PC+4.
- alu_op  output  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
- state  output  4  current FSM state, for debug.
- retired  output  CNT_W  count of completed instructions.
- illegal  output  1  sticky: illegal opcode/funct trap.
- bus_error  output  1  sticky: memory handshake timeout trap.

Behaviour:
- Reset:
  - state=FETCH(0), retired=0, illegal=0, bus_error=0, wait counter=0.
  - While reset is high, all strobes (pc_write, ir_write, sig_reg_write, sig_mem_read, sig_mem_write) are forced 0 combinationally.
  - Reset mid-instruction aborts it: no retire, no write.
- Default outputs: all strobes 0, alu_op=010.
- FETCH(0):
  - ir_write=imem_ready, pc_write=imem_ready, sig_pc_src=0, alu_op=010.
  - imem_ready=1 -> DECODE; otherwise stay and count a wait cycle.
- DECODE(1): no strobes; routes on opcode.
  - 000000 with funct in {100000,100010,100100,100101,101010} -> EXEC_R.
  - 100011 or 101011 -> ADDR.
  - 000100 -> BRANCH.
  - Anything else -> TRAP with illegal=1.
- EXEC_R(2): sig_alu_src=0; alu_op from funct (ADD 010, SUB 110, AND 000, OR 001, SLT 111) -> WB_R.
- WB_R(3): sig_reg_write=1, sig_reg_dst=1, sig_mem_to_reg=0; alu_op held from funct; retire -> FETCH.
- ADDR(4): sig_alu_src=1, alu_op=010; LW -> MEM_RD, SW -> MEM_WR.
- MEM_RD(5): sig_alu_src=1, alu_op=010, sig_mem_read=1 held until dmem_ready=1 -> WB_LW.
- WB_LW(7): sig_reg_write=1, sig_reg_dst=0, sig_mem_to_reg=1; retire -> FETCH.
- MEM_WR(6): sig_alu_src=1, alu_op=010, sig_mem_write=1 held until dmem_ready=1; retire -> FETCH.
- BRANCH(8):
  - alu_op=110; pc_write=zero, sig_pc_src=zero (Mealy on zero).
  - Retire -> FETCH. PC was already advanced to PC+4 in FETCH; the branch target is computed from it.
- TRAP(9):
  - All strobes 0; stays until reset. illegal/bus_error hold their value.
- Wait counter:
  - Increments each cycle in FETCH, MEM_RD or MEM_WR while the relevant ready is 0.
  - Clears on any state change.
  - MAX_WAIT>0 and counter reaches MAX_WAIT with ready still 0 -> TRAP with bus_error=1 next edge, strobes dropped.
- retired: increments by 1 on each retire edge; wraps modulo 2^CNT_W.
- Zero-wait latency: R-type 4 cycles, LW 5, SW 4, BEQ 3.

Decomposition:
- Shared package mips_pkg holds:
  - state encoding constants;
  - opcode constants (RTYPE 000000, LW 100011, SW 101011, BEQ 000100);
  - funct constants;
  - ALU op constants.
- One sub-module, mips_alu_decode: combinational funct -> alu_op plus legal flag. Shared with the single-cycle control path.

Test Plan:
- ADD (opcode 000000, funct 100000), readies tied 1 -> states 0,1,2,3,0; alu_op=010 in EXEC_R; one cycle of sig_reg_write with sig_reg_dst=1; retired 0->1.
- LW, dmem_ready low for 3 cycles in MEM_RD -> sig_mem_read high 4 cycles; WB_LW asserts sig_reg_write with sig_mem_to_reg=1; total 8 cycles; retired increments once.
- BEQ with zero=1 -> BRANCH asserts pc_write=1 and sig_pc_src=1 for one cycle. BEQ with zero=0 -> pc_write=0 in BRANCH. Both take 3 cycles.
- opcode 111111 -> DECODE->TRAP; illegal=1 stays set with readies toggling; reset for 1 cycle clears it, state=0.
- SW with dmem_ready held 0, MAX_WAIT=15 -> sig_mem_write high 15 cycles, then TRAP with bus_error=1, sig_mem_write=0, retired unchanged.
- Reset asserted during MEM_WR -> sig_mem_write=0 in the same cycle; state=0 after the edge; no retire.
